// File: rtl/dma_done_router.sv
`default_nettype none
// ============================================================================
// Module      : dma_done_router
// Description : Records region/PID of each completion-bearing DMA request in
//               grant order and routes in-order XDMA completions back to the
//               issuing region as registered one-cycle done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_done_router #(
    parameter  int N_REG         = 4,
    parameter  int N_OUTSTANDING = 16,
    parameter  int PID_BITS      = 6,
    localparam int c_VFID_W      = (N_REG > 1) ? $clog2(N_REG) : 1,
    localparam int c_CNT_W       = $clog2(N_OUTSTANDING + 1)
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              issue_valid,
    input  logic                              issue_ready,
    input  logic [c_VFID_W-1:0]               issue_vfid,
    input  logic [PID_BITS-1:0]               issue_pid,
    input  logic                              issue_ctl,
    output logic                              issue_stall,
    input  logic                              xdma_done,
    output logic [N_REG-1:0]                  m_done_valid,
    output logic [PID_BITS-1:0]               m_done_pid,
    output logic [N_REG-1:0][c_CNT_W-1:0]     outstanding,
    output logic [N_REG-1:0]                  busy,
    output logic                              err_underflow,
    output logic                              err_overflow
);

    localparam int c_AW    = $clog2(N_OUTSTANDING);
    localparam int c_ENT_W = c_VFID_W + PID_BITS;

    logic [c_ENT_W-1:0]              r_mem [N_OUTSTANDING];
    logic [c_AW:0]                   r_wr_ptr;
    logic [c_AW:0]                   r_rd_ptr;
    logic [N_REG-1:0][c_CNT_W-1:0]   r_cnt;
    logic [N_REG-1:0]                r_done_valid;
    logic [PID_BITS-1:0]             r_done_pid;
    logic                            r_err_underflow;
    logic                            r_err_overflow;

    logic                            w_full;
    logic                            w_empty;
    logic                            w_push_req;
    logic                            w_push;
    logic                            w_pop;
    logic [c_VFID_W-1:0]             w_head_vfid;
    logic [PID_BITS-1:0]             w_head_pid;
    logic [N_REG-1:0]                w_inc;
    logic [N_REG-1:0]                w_dec;

    // Wrap bits differ with equal indices only when the FIFO holds N_OUTSTANDING entries.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push_req = issue_valid & issue_ready & issue_ctl;
    assign w_push     = w_push_req & ~w_full;
    assign w_pop      = xdma_done & ~w_empty;

    assign {w_head_vfid, w_head_pid} = r_mem[r_rd_ptr[c_AW-1:0]];

    // Out-of-range region IDs match no lane, so they still consume a slot and
    // a completion but never touch a count or raise a pulse.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < N_REG; i++) begin
            w_inc[i] = w_push && (issue_vfid  == c_VFID_W'(i));
            w_dec[i] = w_pop  && (w_head_vfid == c_VFID_W'(i));
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {issue_vfid, issue_pid};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cnt           <= '0;
            r_done_valid    <= '0;
            r_done_pid      <= '0;
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            for (int i = 0; i < N_REG; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - c_CNT_W'(1);
                end
            end
            r_done_valid <= w_dec;
            if (|w_dec) begin
                r_done_pid <= w_head_pid;
            end
            if (xdma_done && w_empty) begin
                r_err_underflow <= 1'b1;
            end
            if (w_push_req && w_full) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < N_REG; g++) begin : g_region
            assign outstanding[g] = r_cnt[g];
            assign busy[g]        = |r_cnt[g];
        end
    endgenerate

    assign issue_stall   = w_full;
    assign m_done_valid  = r_done_valid;
    assign m_done_pid    = r_done_pid;
    assign err_underflow = r_err_underflow;
    assign err_overflow  = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dma_done_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_done_router
// Description : Randomised scoreboard bench for dma_done_router against a
//               queue-based model of the ordering FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_done_router;

    localparam int c_NREG = 4;
    localparam int c_NOUT = 16;
    localparam int c_PIDW = 6;
    localparam int c_VW   = 2;
    localparam int c_CW   = 5;

    typedef struct {
        logic [c_VW-1:0]   vfid;
        logic [c_PIDW-1:0] pid;
    } ent_t;

    typedef struct {
        logic [c_NREG-1:0] valid;
        logic [c_PIDW-1:0] pid;
        int                due;
    } exp_t;

    logic                        clk;
    logic                        aresetn;
    logic                        issue_valid;
    logic                        issue_ready;
    logic [c_VW-1:0]             issue_vfid;
    logic [c_PIDW-1:0]           issue_pid;
    logic                        issue_ctl;
    logic                        issue_stall;
    logic                        xdma_done;
    logic [c_NREG-1:0]           m_done_valid;
    logic [c_PIDW-1:0]           m_done_pid;
    logic [c_NREG-1:0][c_CW-1:0] outstanding;
    logic [c_NREG-1:0]           busy;
    logic                        err_underflow;
    logic                        err_overflow;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    ent_t model_q[$];
    exp_t exp_q[$];
    bit   exp_unf  = 0;
    bit   exp_ovf  = 0;

    dma_done_router #(
        .N_REG        (c_NREG),
        .N_OUTSTANDING(c_NOUT),
        .PID_BITS     (c_PIDW)
    ) u_dut (
        .aclk         (clk),
        .aresetn      (aresetn),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_vfid   (issue_vfid),
        .issue_pid    (issue_pid),
        .issue_ctl    (issue_ctl),
        .issue_stall  (issue_stall),
        .xdma_done    (xdma_done),
        .m_done_valid (m_done_valid),
        .m_done_pid   (m_done_pid),
        .outstanding  (outstanding),
        .busy         (busy),
        .err_underflow(err_underflow),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic int model_count(int r);
        int n = 0;
        foreach (model_q[k]) if (int'(model_q[k].vfid) == r) n++;
        return n;
    endfunction

    task automatic check_state();
        chk("issue_stall", issue_stall, model_q.size() == c_NOUT);
        chk("err_underflow", err_underflow, exp_unf);
        chk("err_overflow", err_overflow, exp_ovf);
        for (int r = 0; r < c_NREG; r++) begin
            chk($sformatf("outstanding[%0d]", r), outstanding[r], model_count(r));
            chk($sformatf("busy[%0d]", r), busy[r], model_count(r) != 0);
        end
    endtask

    // One clock of stimulus; the model then applies the same cycle's rules.
    task automatic step(input bit v, input bit rdy, input bit c,
                        input logic [c_VW-1:0] vf, input logic [c_PIDW-1:0] pid,
                        input bit d);
        bit   push_req;
        bit   was_full;
        bit   was_empty;
        ent_t e;
        exp_t x;
        issue_valid = v;
        issue_ready = rdy;
        issue_ctl   = c;
        issue_vfid  = vf;
        issue_pid   = pid;
        xdma_done   = d;
        @(posedge clk);
        #1;
        push_req  = v && rdy && c;
        was_full  = model_q.size() == c_NOUT;
        was_empty = model_q.size() == 0;
        if (push_req && was_full) exp_ovf = 1;
        if (d && was_empty) exp_unf = 1;
        if (d && !was_empty) begin
            e       = model_q.pop_front();
            x.valid = c_NREG'(1) << e.vfid;
            x.pid   = e.pid;
            x.due   = cyc;
            exp_q.push_back(x);
        end
        if (push_req && !was_full) begin
            e.vfid = vf;
            e.pid  = pid;
            model_q.push_back(e);
        end
        issue_valid = 0;
        issue_ready = 0;
        issue_ctl   = 0;
        xdma_done   = 0;
        check_state();
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, 0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (aresetn) begin
            if (m_done_valid != '0) begin
                chk("done_onehot", $onehot0(m_done_valid), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=%0h required=0 (cycle %0d)", m_done_valid, cyc);
                end else begin
                    x = exp_q.pop_front();
                    chk("done_valid", m_done_valid, x.valid);
                    chk("done_pid", m_done_pid, x.pid);
                    chk("done_cycle", cyc, x.due);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                x = exp_q.pop_front();
                chk("missed_pulse", m_done_valid, x.valid);
            end
        end
    end

    initial begin
        bit r_v;
        bit r_c;
        aresetn     = 0;
        issue_valid = 0;
        issue_ready = 0;
        issue_ctl   = 0;
        issue_vfid  = '0;
        issue_pid   = '0;
        xdma_done   = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done_valid", m_done_valid, 0);
        chk("rst_done_pid", m_done_pid, 0);
        check_state();
        aresetn = 1;

        // Two regions, completions return in grant order.
        step(1, 1, 1, 2'd2, 6'd5, 0);
        step(1, 1, 1, 2'd0, 6'd9, 0);
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);
        idle();

        // Non-ctl handshakes leave the FIFO alone; a stray done underflows.
        repeat (3) step(1, 1, 0, 2'd1, 6'd3, 0);
        step(0, 0, 0, '0, '0, 1);
        idle();

        // Fill, overflow, then release stall with one completion.
        for (int i = 0; i < c_NOUT; i++) step(1, 1, 1, 2'd3, 6'(i), 0);
        chk("full_count3", outstanding[3], 16);
        step(1, 1, 1, 2'd3, 6'd63, 0);
        step(0, 0, 0, '0, '0, 1);
        repeat (c_NOUT - 1) step(0, 0, 0, '0, '0, 1);
        idle();

        // Same-cycle push and pop on the same region at occupancy 5.
        for (int i = 0; i < 5; i++) step(1, 1, 1, 2'd1, 6'(10 + i), 0);
        step(1, 1, 1, 2'd1, 6'd20, 1);
        chk("occ5_count1", outstanding[1], 5);
        repeat (5) step(0, 0, 0, '0, '0, 1);
        idle();

        // Randomised traffic honouring the stall contract.
        for (int i = 0; i < 160; i++) begin
            r_v = ($urandom_range(0, 3) != 0);
            r_c = ($urandom_range(0, 3) != 0) && (model_q.size() != c_NOUT);
            step(r_v, $urandom_range(0, 4) != 0, r_c,
                 c_VW'($urandom_range(0, c_NREG - 1)),
                 c_PIDW'($urandom_range(0, 63)),
                 $urandom_range(0, 1) == 1);
        end
        while (model_q.size() != 0) step(0, 0, 0, '0, '0, 1);
        repeat (2) idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        // Asynchronous reset with a pulse in flight and entries pending.
        for (int i = 0; i < 8; i++) step(1, 1, 1, c_VW'(i % c_NREG), 6'(30 + i), 0);
        step(0, 0, 0, '0, '0, 1);
        xdma_done = 1;
        #1;
        aresetn = 0;
        #1;
        exp_q.delete();
        model_q.delete();
        exp_unf = 0;
        exp_ovf = 0;
        chk("arst_done_valid", m_done_valid, 0);
        chk("arst_done_pid", m_done_pid, 0);
        check_state();
        @(posedge clk);
        #1;
        xdma_done = 0;
        aresetn   = 1;
        idle();
        step(1, 1, 1, 2'd2, 6'd44, 0);
        step(0, 0, 0, '0, '0, 1);
        repeat (2) idle();
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_done_router.md
Name: dma_done_router

Overview:
- Return path of the host-DMA arbitration in the MMU top level.
- The arbiter funnels per-region host DMA requests into one XDMA channel. This block records the issuing region and PID of every completion-bearing request, in grant order.
- The XDMA engine returns in-order completion pulses. This block steers each one back to its originating region as a one-cycle done pulse.
- It also keeps per-region outstanding counts, used for decoupling and drain decisions.

Parameters:
- N_REG, 4, number of vFPGA regions served (1..16).
- N_OUTSTANDING, 16, depth of the ordering FIFO (power of two, >=2).
- PID_BITS, 6, width of the process ID returned with each completion.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  request handshake valid on the XDMA request channel (observed, not driven).
- issue_ready  in  1  XDMA request channel ready.
- issue_vfid  in  clog2(N_REG) (min 1)  region of the granted request.
- issue_pid  in  PID_BITS  process ID of the granted request.
- issue_ctl  in  1  request expects a completion (last fragment of a transfer).
- issue_stall  out  1  asserted when the ordering FIFO is full; the arbiter must not grant a ctl request while it is high.
- xdma_done  in  1  single-cycle completion pulse from XDMA, in issue order.
- m_done_valid  out  N_REG  per-region one-cycle done pulse.
- m_done_pid  out  PID_BITS  PID accompanying m_done_valid (shared).
- outstanding  out  N_REG x clog2(N_OUTSTANDING+1)  per-region count of issued-but-not-completed requests.
- busy  out  N_REG  outstanding[i] != 0.
- err_underflow  out  1  sticky: completion arrived with an empty FIFO.
- err_overflow  out  1  sticky: push attempted while full.

Behaviour:
- Reset (async, aresetn=0): FIFO empty, all counts 0. All of m_done_valid, m_done_pid, issue_stall, busy, err_underflow and err_overflow are 0. Release is synchronous to aclk.
- Push condition: issue_valid & issue_ready & issue_ctl. Writes {vfid, pid} at the write pointer. Handshakes with issue_ctl=0 are ignored entirely.
- Pop condition: xdma_done & !empty. Reads the head entry, advances the read pointer, and decrements outstanding[head.vfid].
- Done output timing:
  - m_done_valid[head.vfid] and m_done_pid are registered, asserted exactly one cycle after xdma_done, high for one cycle.
  - m_done_pid holds its last value when no pulse is active.
  - m_done_valid is at most one-hot.
- Outstanding count: outstanding[vfid] increments on push.
- Same-cycle push and pop:
  - Both take effect. FIFO occupancy is unchanged.
  - If push and pop target the same region, that count is unchanged.
  - If they target different regions, one count increments and the other decrements.
- Full (occupancy == N_OUTSTANDING):
  - issue_stall=1, combinationally from the registered occupancy.
  - A push while full is dropped and sets err_overflow, even if a pop occurs in the same cycle. The stall contract forbids this push, so the rule stays simple.
- Empty:
  - xdma_done with an empty FIFO is dropped, no pulse is generated, and err_underflow is set.
  - A same-cycle push into an empty FIFO is not bypassed to the pop. The pushed entry waits for the next xdma_done.
- Pointers: log2(N_OUTSTANDING)+1 bits with a wrap bit. Full/empty is decided by comparing wrap bits. Wrap-around is seamless.
- issue_vfid >= N_REG: the entry is pushed but the count update and done pulse are suppressed. The entry still consumes one completion.
- Sticky errors clear only on reset.
- Reset asserted mid-operation: all state is discarded immediately. Any pending done pulse is dropped, and m_done_valid goes 0 asynchronously.
- No combinational path from xdma_done to any output. The only combinational output path is issue_stall from the occupancy register.

Test Plan:
- Push ctl from vfid 2 (pid 5), then vfid 0 (pid 9); pulse xdma_done twice -> m_done_valid=0100 with pid 5, then 0001 with pid 9, each one cycle after its done; outstanding returns to 0.
- Handshakes with issue_ctl=0 from vfid 1, x3 -> no FIFO change; outstanding[1]=0; a subsequent xdma_done sets err_underflow and produces no pulse.
- Fill 16 ctl pushes from vfid 3 -> issue_stall=1, outstanding[3]=16; a 17th push sets err_overflow; one done -> issue_stall=0 the next cycle.
- Same-cycle push (vfid 1) and done (head vfid 1) at occupancy 5 -> occupancy stays 5, outstanding[1] unchanged, m_done_valid=0010 the next cycle.
- Cycle 40 push/pop pairs across regions with random pids (wrap pointers twice) -> pulses match the scoreboard's issue order exactly.
- Assert aresetn low with 7 entries pending and a done pulse scheduled -> all outputs 0 immediately; after release, FIFO empty and busy=0.
